// File: rtl/mem_bridge.sv
// CPU-to-bus bridge: captures one CPU read/write, issues it downstream with a
// valid/ready handshake, waits for completion, and returns a one-cycle response.
module mem_bridge #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_addr,
   input  logic [3:0]  cpu_rmask,
   input  logic [3:0]  cpu_wmask,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_resp,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_wmask,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic        we_q, we_d;
   logic        valid_q, valid_d;
   logic        resp_q, resp_d;
   logic        err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wmask_d = wmask_q;
      we_d    = we_q;
      resp_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Read wins when both masks are set; wmask is then dropped.
            if (cpu_rmask != 4'd0) begin
               state_d = REQ;
               cnt_d   = 16'd0;
               addr_d  = {cpu_addr[31:2], 2'b00};
               we_d    = 1'b0;
               wmask_d = 4'd0;
            end else if (cpu_wmask != 4'd0) begin
               state_d = REQ;
               cnt_d   = 16'd0;
               addr_d  = {cpu_addr[31:2], 2'b00};
               we_d    = 1'b1;
               wmask_d = cpu_wmask;
               wdata_d = cpu_wdata;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == TMO_LAST) begin
               state_d = RESP;
               rdata_d = 32'd0;
               resp_d  = 1'b1;
               err_d   = 1'b1;
            end else if (bus_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // A completion arriving on the timeout cycle still counts as normal.
            if (bus_rvalid) begin
               state_d = RESP;
               rdata_d = we_q ? 32'd0 : bus_rdata;
               resp_d  = 1'b1;
            end else if (cnt_q == TMO_LAST) begin
               state_d = RESP;
               rdata_d = 32'd0;
               resp_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         wmask_q <= 4'd0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wmask_q <= wmask_d;
         we_q    <= we_d;
         valid_q <= valid_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_resp  = resp_q;
   assign err       = err_q;
   assign bus_valid = valid_q;
   assign bus_addr  = addr_q;
   assign bus_we    = we_q;
   assign bus_wmask = wmask_q;
   assign bus_wdata = wdata_q;

endmodule
